// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch handshake between the fetch stage (master) and imem (slave).
// imem_rdata is valid in the same cycle that imem_ready is high.
interface fetch_stage_if #(
    parameter int ADDR_W = 16
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [15:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry stall buffer and branch redirect.
// Optional breakpoint halt enabled by defining FETCH_HALT_EN.
module fetch_stage #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [15:0]       NOP_INSTR = 16'hBF00
) (
    input  logic              clk,
    input  logic              reset,
    fetch_stage_if.master     imem,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [15:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              halted
);

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_pc,        w_pc_nxt;
    logic [15:0]       r_buf_instr, w_buf_instr_nxt;
    logic [ADDR_W-1:0] r_buf_pc,    w_buf_pc_nxt;
    logic              r_redir,     w_redir_nxt;
    logic [ADDR_W-1:0] r_redir_tgt, w_redir_tgt_nxt;
    logic [15:0]       r_instr,     w_instr_nxt;
    logic [ADDR_W-1:0] r_id_pc,     w_id_pc_nxt;
    logic              r_valid,     w_valid_nxt;
    logic              r_halted,    w_halted_nxt;

    logic [ADDR_W-1:0] w_tgt;
    logic              w_fire;
    logic              w_redir_now;
    logic              w_bkpt;

    assign w_tgt       = branch_target & ~ADDR_W'(1);
    assign w_fire      = (r_state == FETCH) && !r_halted && imem.imem_ready;
    assign w_redir_now = branch_taken || r_redir;
    assign w_bkpt      = HALT_EN && (imem.imem_rdata[15:8] == 8'hBE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = FETCH;
            FETCH:   if (w_fire && !w_redir_now && stall) w_state_nxt = HELD;
            HELD:    if (branch_taken || !stall) w_state_nxt = FETCH;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem.imem_req = (r_state == FETCH) && !r_halted;
    end

    assign imem.imem_addr = r_pc;

    // Datapath next values; a redirect always wins over stall and produces a bubble
    always_comb begin
        w_pc_nxt        = r_pc;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_pc_nxt    = r_buf_pc;
        w_redir_nxt     = r_redir;
        w_redir_tgt_nxt = r_redir_tgt;
        w_instr_nxt     = r_instr;
        w_id_pc_nxt     = r_id_pc;
        w_valid_nxt     = r_valid;
        w_halted_nxt    = r_halted;
        case (r_state)
            FETCH: begin
                if (w_fire) begin
                    if (w_redir_now) begin
                        w_pc_nxt    = branch_taken ? w_tgt : r_redir_tgt;
                        w_redir_nxt = 1'b0;
                        w_instr_nxt = NOP_INSTR;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_pc_nxt = r_pc + ADDR_W'(2);
                        if (w_bkpt) w_halted_nxt = 1'b1;
                        if (stall) begin
                            w_buf_instr_nxt = imem.imem_rdata;
                            w_buf_pc_nxt    = r_pc;
                        end else begin
                            w_instr_nxt = imem.imem_rdata;
                            w_id_pc_nxt = r_pc;
                            w_valid_nxt = 1'b1;
                        end
                    end
                end else if (branch_taken) begin
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                    // No request is outstanding while halted, so redirect immediately
                    if (r_halted) begin
                        w_pc_nxt     = w_tgt;
                        w_halted_nxt = 1'b0;
                    end else begin
                        w_redir_nxt     = 1'b1;
                        w_redir_tgt_nxt = w_tgt;
                    end
                end else if (!stall) begin
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                end
            end
            HELD: begin
                if (branch_taken) begin
                    w_pc_nxt     = w_tgt;
                    w_halted_nxt = 1'b0;
                    w_instr_nxt  = NOP_INSTR;
                    w_valid_nxt  = 1'b0;
                end else if (!stall) begin
                    w_instr_nxt = r_buf_instr;
                    w_id_pc_nxt = r_buf_pc;
                    w_valid_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_buf_instr <= NOP_INSTR;
            r_buf_pc    <= '0;
            r_redir     <= 1'b0;
            r_redir_tgt <= '0;
            r_instr     <= NOP_INSTR;
            r_id_pc     <= '0;
            r_valid     <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
            r_redir     <= w_redir_nxt;
            r_redir_tgt <= w_redir_tgt_nxt;
            r_instr     <= w_instr_nxt;
            r_id_pc     <= w_id_pc_nxt;
            r_valid     <= w_valid_nxt;
            r_halted    <= w_halted_nxt;
        end
    end

    assign if_id_instr = r_instr;
    assign if_id_pc    = r_id_pc;
    assign if_id_valid = r_valid;
    assign halted      = r_halted;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register for the 16-bit 5-stage pipeline; sits directly upstream of the decode/control logic.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Handles stalls with a one-entry hold buffer, redirects the PC on taken branches, and injects NOP bubbles (16'hBF00, which decode treats as no-op) whenever no valid instruction is available.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'hBF00, bubble encoding driven into IF/ID.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  ADDR_W  fetch address; equals PC.
- imem_ready  input  1  response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  input  16  fetched instruction.
- stall  input  1  hazard unit request to hold IF/ID.
- branch_taken  input  1  redirect request; squashes younger instructions.
- branch_target  input  ADDR_W  redirect address; bit 0 is ignored and forced to 0.
- if_id_instr  output  16  instruction to decode.
- if_id_pc  output  ADDR_W  address of if_id_instr.
- if_id_valid  output  1  high when if_id_instr is a real fetched instruction.
- halted  output  1  fetch halted (see Optional Feature).

Behaviour:
- Reset (asynchronous) values:
  - PC=RESET_PC, state=IDLE.
  - imem_req=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0.
  - hold buffer empty, redirect_pending=0, halted=0.
- States: IDLE, FETCH, HELD.
- IDLE: imem_req=0. Always moves to FETCH on the next edge. Exists only for the first cycle after reset release.
- FETCH: imem_req=1, imem_addr=PC. imem_addr must stay stable while imem_req=1 and imem_ready=0.
  - imem_ready=1 and (branch_taken or redirect_pending): response discarded; PC<=target (branch_taken's target wins over the pending one); redirect_pending<=0; IF/ID<=NOP, valid 0; stay in FETCH.
  - imem_ready=1, no redirect, stall=1: IF/ID holds; rdata and PC go into the hold buffer; PC<=PC+2; go to HELD.
  - imem_ready=1, no redirect, stall=0: IF/ID<=rdata, PC, valid 1; PC<=PC+2.
  - imem_ready=0 and branch_taken: redirect_pending<=1 and pending_target<=branch_target; IF/ID<=NOP, valid 0. The outstanding request is not aborted.
  - imem_ready=0, no branch: if stall, IF/ID holds; otherwise IF/ID<=NOP, valid 0.
- HELD: imem_req=0.
  - branch_taken: buffer dropped; PC<=branch_target; IF/ID<=NOP, valid 0; go to FETCH.
  - stall=0: IF/ID<=buffer contents, valid 1; go to FETCH.
  - Otherwise stay in HELD.
- Priority: reset > branch_taken > stall. A branch and a stall in the same cycle always produce a NOP bubble, never a hold.
- PC arithmetic: PC+2 modulo 2^ADDR_W, so 0xFFFE wraps to 0x0000.
- Latency: with imem_ready tied high, the first valid if_id_instr appears after the 2nd rising edge following reset release; after that, one instruction per cycle.
- Order guarantee: no instruction is duplicated or lost across any stall, branch, or wait-state combination.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - A non-discarded fetched word with [15:8]=8'hBE (BKPT) is passed to IF/ID normally, then halted<=1.
  - While halted: imem_req=0, IF/ID receives NOP bubbles (or holds while stall=1), PC is frozen at BKPT address+2.
  - branch_taken clears halted and redirects as usual. reset also clears it.
- Undefined: halted is tied to 0 and BKPT is fetched like any other instruction.

Test Plan:
- RESET_PC=0, imem_ready=1, imem_rdata=addr^16'h5A5A -> imem_addr 0x0000,0x0002,0x0004; if_id_pc follows one cycle later with valid=1 and matching data; first valid after the 2nd edge.
- imem_ready low for 3 cycles on address 0x0006 -> imem_addr held at 0x0006; if_id_instr=0xBF00 with valid=0 for those cycles; 0x0006 delivered once ready rises.
- stall high for 2 cycles while ready=1 at 0x0008 -> IF/ID holds 0x0006; state HELD with imem_req=0; after stall drops, 0x0008 then 0x000A delivered with no gap or duplicate.
- branch_taken with target 0x0041 while the 0x0010 request is waiting, ready 2 cycles later -> 0x0010 data discarded; next imem_addr=0x0040; valid 0 until 0x0040 is delivered.
- branch_taken and stall in the same cycle with target 0x0100 -> if_id_instr=0xBF00, valid=0; next fetch at 0x0100.
- RESET_PC=0xFFFC, then reset asserted mid-wait -> addresses 0xFFFC,0xFFFE,0x0000 before the reset; all outputs return to reset values immediately on assertion, with no clock edge needed; fetch restarts at 0xFFFC.
